// File: rtl/chrono_core.sv
// chrono_core: stopwatch time-keeping core.
//
// Counts MM:SS.t in BCD on each tenth-second tick. A four-state FSM
// (IDLE/RUN/LAP/STOP) sequences the start/stop, lap and clear commands.
// The display shows either the live count or a frozen lap snapshot.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset (0 = reset)
//   tick        one-cycle pulse per tenth of a second
//   start_stop  one-cycle command pulse: start / stop / resume
//   lap         one-cycle command pulse: take / retake a lap snapshot
//   clear       one-cycle command pulse: zero everything (from STOP only)
//   disp_*      BCD digits MM:SS.t driven to the display multiplexer
//   running     1 in RUN or LAP
//   lap_active  1 in LAP
//   overflow    sticky flag, set when the count wraps past MAX_MIN:59.9
module chrono_core #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] disp_min_t,
    output logic [3:0] disp_min_u,
    output logic [3:0] disp_sec_t,
    output logic [3:0] disp_sec_u,
    output logic [3:0] disp_tenth,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAP  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);

    // Count layout: {min_t, min_u, sec_t, sec_u, tenth}
    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] lap_q, lap_d;
    logic        ovf_q, ovf_d;
    logic [20:0] inc_res;
    logic [19:0] disp_sel;

    // One-tenth increment with the whole carry chain resolved combinationally.
    // Bit 20 of the result flags a wrap from MAX_MIN:59.9 to 00:00.0.
    function automatic logic [20:0] bcd_inc(input logic [19:0] c);
        logic [3:0] mt, mu, st, su, t;
        logic       wrap;
        {mt, mu, st, su, t} = c;
        wrap = 1'b0;
        if (t != 4'd9) begin
            t = t + 4'd1;
        end else begin
            t = 4'd0;
            if (su != 4'd9) begin
                su = su + 4'd1;
            end else begin
                su = 4'd0;
                if (st != 4'd5) begin
                    st = st + 4'd1;
                end else begin
                    st = 4'd0;
                    if (mt == MAX_T && mu == MAX_U) begin
                        mt   = 4'd0;
                        mu   = 4'd0;
                        wrap = 1'b1;
                    end else if (mu != 4'd9) begin
                        mu = mu + 4'd1;
                    end else begin
                        mu = 4'd0;
                        mt = mt + 4'd1;
                    end
                end
            end
        end
        return {wrap, mt, mu, st, su, t};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        inc_res = bcd_inc(cnt_q);

        // Counting follows the registered state, so a tick coinciding with
        // a stop is still counted and one coinciding with a start is not.
        if (tick && (state_q == S_RUN || state_q == S_LAP)) begin
            cnt_d = inc_res[19:0];
            if (inc_res[20]) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_LAP: begin
                if (start_stop) begin
                    state_d = S_STOP;
                end else if (lap) begin
                    state_d = S_LAP;
                    lap_d   = cnt_q;
                end
            end
            S_STOP: begin
                if (clear) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    lap_d   = '0;
                    ovf_d   = 1'b0;
                end else if (start_stop) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
        end
    end

    // Display is a plain mux of registered sources; no extra pipeline stage.
    assign disp_sel   = (state_q == S_LAP) ? lap_q : cnt_q;
    assign disp_min_t = disp_sel[19:16];
    assign disp_min_u = disp_sel[15:12];
    assign disp_sec_t = disp_sel[11:8];
    assign disp_sec_u = disp_sel[7:4];
    assign disp_tenth = disp_sel[3:0];
    assign running    = (state_q == S_RUN) || (state_q == S_LAP);
    assign lap_active = (state_q == S_LAP);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_chrono_core.sv
module tb_chrono_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] disp_min_t, disp_min_u, disp_sec_t, disp_sec_u, disp_tenth;
    logic       running, lap_active, overflow;

    chrono_core #(.MAX_MIN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp_min_t (disp_min_t),
        .disp_min_u (disp_min_u),
        .disp_sec_t (disp_sec_t),
        .disp_sec_u (disp_sec_u),
        .disp_tenth (disp_tenth),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] disp;
        logic        run;
        logic        lapa;
        logic        ovf;
    } exp_t;

    typedef struct {
        string name;
        logic  tk, ss, lp, cl;
        int    reps;
        int    exp0;   // shown time in tenths after the first cycle of the row
        int    stepv;  // added to the shown time on each further repetition
        logic  run, lapa, ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference conversion from an integer number of tenths to MM:SS.t digits.
    function automatic logic [19:0] to_bcd(input int tn);
        int m, s, t;
        m = tn / 600;
        s = (tn / 10) % 60;
        t = tn % 10;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t)};
    endfunction

    function automatic exp_t mk(input int tn, input logic r, input logic la, input logic o);
        exp_t e;
        e.disp = to_bcd(tn);
        e.run  = r;
        e.lapa = la;
        e.ovf  = o;
        return e;
    endfunction

    task automatic add(input string nm, input logic tk, input logic ss, input logic lp,
                       input logic cl, input int reps, input int e0, input int st,
                       input logic r, input logic la, input logic o);
        vec_t v;
        v.name = nm; v.tk = tk; v.ss = ss; v.lp = lp; v.cl = cl;
        v.reps = reps; v.exp0 = e0; v.stepv = st;
        v.run = r; v.lapa = la; v.ovf = o;
        vecs.push_back(v);
    endtask

    task automatic compare(input string nm, input exp_t e);
        exp_t a;
        a = {disp_min_t, disp_min_u, disp_sec_t, disp_sec_u, disp_tenth,
             running, lap_active, overflow};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got disp=%h run=%b lap=%b ovf=%b, want disp=%h run=%b lap=%b ovf=%b",
                     nm, a.disp, a.run, a.lapa, a.ovf, e.disp, e.run, e.lapa, e.ovf);
        end
    endtask

    task automatic check_sb(input string nm);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            compare(nm, sb.pop_front());
        end
    endtask

    // Drive one cycle of commands, queue the expectation, check after the edge.
    task automatic step(input string nm, input logic tk, input logic ss, input logic lp,
                        input logic cl, input exp_t e);
        @(negedge clk);
        tick = tk; start_stop = ss; lap = lp; clear = cl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_sb(nm);
    endtask

    initial begin
        // MAX_MIN = 1, so the count wraps after 01:59.9 (1199 tenths).
        add("idle_tick",    1, 0, 0, 0,    1,   0, 0, 0, 0, 0);
        add("idle_lap",     0, 0, 1, 0,    1,   0, 0, 0, 0, 0);
        add("idle_clear",   0, 0, 0, 1,    1,   0, 0, 0, 0, 0);
        add("start",        0, 1, 0, 0,    1,   0, 0, 1, 0, 0);
        add("count10",      1, 0, 0, 0,   10,   1, 1, 1, 0, 0);
        add("stop",         0, 1, 0, 0,    1,  10, 0, 0, 0, 0);
        add("stopped_tick", 1, 0, 0, 0,    5,  10, 0, 0, 0, 0);
        add("resume_tick",  1, 1, 0, 0,    1,  10, 0, 1, 0, 0);
        add("run_clear",    0, 0, 0, 1,    1,  10, 0, 1, 0, 0);
        add("to_5_3",       1, 0, 0, 0,   43,  11, 1, 1, 0, 0);
        add("lap1",         0, 0, 1, 0,    1,  53, 0, 1, 1, 0);
        add("lap_hold",     1, 0, 0, 0,   20,  53, 0, 1, 1, 0);
        add("lap2",         0, 0, 1, 0,    1,  73, 0, 1, 1, 0);
        add("lap_stop",     0, 1, 0, 0,    1,  73, 0, 0, 0, 0);
        add("resume",       0, 1, 0, 0,    1,  73, 0, 1, 0, 0);
        add("stop_tick",    1, 1, 0, 0,    1,  74, 0, 0, 0, 0);
        add("stopped2",     1, 0, 0, 0,    2,  74, 0, 0, 0, 0);
        add("clear_all",    0, 1, 1, 1,    1,   0, 0, 0, 0, 0);
        add("idle_tick2",   1, 0, 0, 0,    1,   0, 0, 0, 0, 0);
        add("start2",       0, 1, 0, 0,    1,   0, 0, 1, 0, 0);
        add("to_max",       1, 0, 0, 0, 1199,   1, 1, 1, 0, 0);
        add("wrap",         1, 0, 0, 0,    1,   0, 0, 1, 0, 1);
        add("after_wrap",   1, 0, 0, 0,    5,   1, 1, 1, 0, 1);
        add("stop3",        0, 1, 0, 0,    1,   5, 0, 0, 0, 1);
        add("stop_lap_ign", 0, 0, 1, 0,    1,   5, 0, 0, 0, 1);
        add("clear3",       0, 0, 0, 1,    1,   0, 0, 0, 0, 0);

        // Reset state, with command pulses that must be ignored while held.
        repeat (2) @(posedge clk);
        tick = 1'b1; start_stop = 1'b1;
        @(posedge clk);
        #1;
        compare("reset_state", mk(0, 0, 0, 0));
        @(negedge clk);
        tick = 1'b0; start_stop = 1'b0;
        rst = 1'b1;

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                step(vecs[i].name, vecs[i].tk, vecs[i].ss, vecs[i].lp, vecs[i].cl,
                     mk(vecs[i].exp0 + k * vecs[i].stepv, vecs[i].run, vecs[i].lapa, vecs[i].ovf));
            end
        end

        // Asynchronous reset while in LAP at 01:23.4.
        step("rl_start", 0, 1, 0, 0, mk(0, 1, 0, 0));
        for (int k = 1; k <= 834; k++) begin
            step("rl_count", 1, 0, 0, 0, mk(k, 1, 0, 0));
        end
        step("rl_lap", 0, 0, 1, 0, mk(834, 1, 1, 0));
        for (int k = 0; k < 3; k++) begin
            step("rl_hold", 1, 0, 0, 0, mk(834, 1, 1, 0));
        end
        #2;
        rst = 1'b0;
        #1;
        compare("async_reset", mk(0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("post_reset_tick", 1, 0, 0, 0, mk(0, 0, 0, 0));
        end
        step("post_reset_start", 0, 1, 0, 0, mk(0, 1, 0, 0));
        step("post_reset_count", 1, 0, 0, 0, mk(1, 1, 0, 0));
        @(negedge clk);
        tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chrono_core.md
# chrono_core

Stopwatch time-keeping core that consumes the one-cycle tick pulse produced by the design's prescaler. Each tick is one tenth of a second. The core counts MM:SS.t in BCD, sequences start/stop/lap/clear commands through a small state machine, and drives the digit values to the display multiplexer.

## Interface
Parameters:
- MAX_MIN, default 59: highest minutes value (decimal, 1..99) before wrap-around.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous assertion, active-low (0 = reset).
- tick  input  1  one-cycle pulse, one per tenth-second, from the tick generator.
- start_stop  input  1  one-cycle pulse; debounced upstream.
- lap  input  1  one-cycle pulse; debounced upstream.
- clear  input  1  one-cycle pulse; debounced upstream.
- disp_min_t  output  4  BCD minutes tens shown on the display.
- disp_min_u  output  4  BCD minutes units.
- disp_sec_t  output  4  BCD seconds tens (0..5).
- disp_sec_u  output  4  BCD seconds units.
- disp_tenth  output  4  BCD tenths.
- running  output  1  1 in RUN or LAP.
- lap_active  output  1  1 in LAP.
- overflow  output  1  sticky flag; set on wrap-around.

## Operation
- Internal live count: five BCD digits. Separate lap register: five BCD digits.
- States:
  - IDLE: count zero, stopped.
  - RUN: counting; display shows the live count.
  - LAP: counting; display shows the frozen lap register.
  - STOP: not counting; display shows the live count.
- Transitions. Only commands valid in the current state act. Priority is clear > start_stop > lap when several are valid in the same cycle.
  - IDLE: start_stop -> RUN. lap and clear are ignored.
  - RUN: start_stop -> STOP. lap -> LAP, and the live count is copied to the lap register on the same edge. clear is ignored.
  - LAP: start_stop -> STOP, and the display returns to the live count. lap -> LAP, and the lap register is reloaded with the live count. clear is ignored.
  - STOP: start_stop -> RUN (resume without zeroing). clear -> IDLE, zeroing the live count, the lap register and overflow. lap is ignored.
- Counting:
  - The live count increments by one tenth on a tick cycle when the registered state is RUN or LAP.
  - A tick in the same cycle as a stop is counted.
  - A tick in the same cycle as a start from STOP or IDLE is not counted.
- Carry chain:
  - tenth 9 -> 0, with carry into seconds.
  - seconds 59 -> 00, with carry into minutes.
  - minutes MAX_MIN -> 00.
- Wrap-around: MAX_MIN:59.9 plus a tick gives 00:00.0. overflow is set and stays set until clear or reset. Counting continues.
- Digits always hold valid BCD. No digit ever shows a value above 9, and disp_sec_t never exceeds 5.
- The lap register is updated only by lap commands and clear. It is otherwise stable.

## Timing
- Reset value of every output:
  - all disp_* = 0.
  - running = 0, lap_active = 0, overflow = 0.
  - state = IDLE.
- Reset is asynchronous and takes effect immediately, including mid-count or in LAP. All registers return to reset values.
- Command latency: a command sampled at edge N changes the state, running and lap_active from edge N onward. Outputs are visible in cycle N+1.
- Tick latency: a tick sampled at edge N updates the digits from edge N (visible in cycle N+1). The full carry chain resolves in that same edge; no multi-cycle ripple.
- Display outputs are a combinational mux of registered sources (live count or lap register) selected by the registered state. There is no added pipeline stage.
- Back-to-back ticks on consecutive cycles must each increment. The core does not assume any minimum tick spacing.
- The inputs are single-cycle pulses. A level held for k cycles is treated as k commands. For example, a held start_stop toggles RUN/STOP on every cycle.

## Test plan
- Reset, then start_stop, then 10 ticks, then start_stop -> display shows 00:01.0; running=0; further ticks leave the display unchanged.
- Running, then lap at 00:05.3, then 20 ticks -> display holds 00:05.3 and lap_active=1. A second lap shows 00:07.3. Then start_stop gives the live count 00:07.3 with running=0.
- Preload by ticking to MAX_MIN:59.9 (use MAX_MIN=1 for a short run), then one tick -> display shows 00:00.0 and overflow=1. clear from STOP -> overflow=0 and state is IDLE.
- In RUN, start_stop and tick in the same cycle -> the tick is counted and the state becomes STOP. In STOP, start_stop and tick in the same cycle -> the tick is not counted.
- In STOP, clear, start_stop and lap in the same cycle -> the result is IDLE with all digits 0. In RUN, clear alone is ignored.
- Assert rst mid-count in LAP at 01:23.4 -> all outputs go to 0 immediately (asynchronously). After release, the state is IDLE and ticks are ignored until start_stop.
